// File: rtl/io_bus_responder.sv
// Memory-mapped I/O slave on the data bus: output port, synchronized/edge-detected input port,
// optional compare timer (build with IO_TIMER_EN) and a level interrupt.
module io_bus_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
    parameter int unsigned IN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    output logic [31:0]         ReadData,
    output logic                Hit,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         PortOut,
    output logic                Irq
);

    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        REG_OUT   = 3'd0,
        REG_IN    = 3'd1,
        REG_EDGE  = 3'd2,
        REG_IEN   = 3'd3,
        REG_TCMP  = 3'd4,
        REG_TCNT  = 3'd5,
        REG_TSTAT = 3'd6,
        REG_RSVD  = 3'd7
    } reg_idx_e;

    reg_idx_e            idx;
    logic                wr_sel;
    logic                we_out;
    logic                we_edge;
    logic                we_ien;
    logic [IN_WIDTH-1:0] s1_q;
    logic [IN_WIDTH-1:0] s2_q;
    logic [IN_WIDTH-1:0] s3_q;
    logic [IN_WIDTH-1:0] rise;
    logic [IN_WIDTH-1:0] edge_clr;
    logic [IN_WIDTH-1:0] edge_q;
    logic [IN_WIDTH-1:0] edge_en_q;
    logic [DATA_W-1:0]   out_q;
    logic [DATA_W-1:0]   ien_rd;
    logic                unused_addr;

    // Byte-lane bits are don't-care for word registers.
    assign unused_addr = ^Address[1:0];

    assign Hit     = (Address[31:5] == BASE_ADDR[31:5]);
    assign idx     = reg_idx_e'(Address[4:2]);
    assign wr_sel  = MemWrite & Hit;
    assign we_out  = wr_sel & (idx == REG_OUT);
    assign we_edge = wr_sel & (idx == REG_EDGE);
    assign we_ien  = wr_sel & (idx == REG_IEN);

    // Two-flop synchronizer plus one delay stage for rising-edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= PortIn;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise     = s2_q & ~s3_q;
    assign edge_clr = we_edge ? WriteData[IN_WIDTH-1:0] : '0;

    // Output register, sticky edge flags (hardware set beats W1C) and edge enables.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q     <= '0;
            edge_q    <= '0;
            edge_en_q <= '0;
        end else begin
            if (we_out) begin
                out_q <= WriteData;
            end
            edge_q <= (edge_q & ~edge_clr) | rise;
            if (we_ien) begin
                edge_en_q <= WriteData[IN_WIDTH-1:0];
            end
        end
    end

    assign PortOut = out_q;

`ifdef IO_TIMER_EN
    logic              we_tcmp;
    logic              we_tcnt;
    logic              we_tstat;
    logic              cnt_eq;
    logic              match_set;
    logic              match_clr;
    logic [DATA_W-1:0] tcmp_q;
    logic [DATA_W-1:0] tcnt_q;
    logic              match_q;
    logic              run_q;
    logic              tim_en_q;

    assign we_tcmp   = wr_sel & (idx == REG_TCMP);
    assign we_tcnt   = wr_sel & (idx == REG_TCNT);
    assign we_tstat  = wr_sel & (idx == REG_TSTAT);
    assign cnt_eq    = (tcnt_q == tcmp_q);
    // A software counter load suppresses the compare event in the same cycle.
    assign match_set = run_q & cnt_eq & ~we_tcnt;
    assign match_clr = we_tstat & WriteData[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcmp_q   <= '1;
            tcnt_q   <= '0;
            match_q  <= 1'b0;
            run_q    <= 1'b0;
            tim_en_q <= 1'b0;
        end else begin
            if (we_tcmp) begin
                tcmp_q <= WriteData;
            end
            if (we_tcnt) begin
                tcnt_q <= WriteData;
            end else if (run_q) begin
                tcnt_q <= cnt_eq ? '0 : tcnt_q + DATA_W'(1);
            end
            match_q <= match_set | (match_q & ~match_clr);
            if (we_tstat) begin
                run_q <= WriteData[1];
            end
            if (we_ien) begin
                tim_en_q <= WriteData[31];
            end
        end
    end

    always_comb begin
        ien_rd     = DATA_W'(edge_en_q);
        ien_rd[31] = tim_en_q;
    end

    assign Irq = (|(edge_q & edge_en_q)) | (match_q & tim_en_q);
`else
    always_comb begin
        ien_rd = DATA_W'(edge_en_q);
    end

    assign Irq = |(edge_q & edge_en_q);
`endif

    // Combinational read of registered state; a same-cycle write is not yet visible.
    always_comb begin
        ReadData = '0;
        if (MemRead && Hit) begin
            case (idx)
                REG_OUT:   ReadData = out_q;
                REG_IN:    ReadData = DATA_W'(s2_q);
                REG_EDGE:  ReadData = DATA_W'(edge_q);
                REG_IEN:   ReadData = ien_rd;
`ifdef IO_TIMER_EN
                REG_TCMP:  ReadData = tcmp_q;
                REG_TCNT:  ReadData = tcnt_q;
                REG_TSTAT: ReadData = {30'd0, run_q, match_q};
`endif
                default:   ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_bus_responder.sv
// Bench for io_bus_responder: directed register/timer/reset scenarios plus randomized bus traffic
// checked against a register-level reference model. Timer checks follow IO_TIMER_EN.
module tb_io_bus_responder;

    localparam int unsigned IW   = 8;
    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam logic [31:0] A_OUT   = BASE + 32'h00;
    localparam logic [31:0] A_IN    = BASE + 32'h04;
    localparam logic [31:0] A_EDGE  = BASE + 32'h08;
    localparam logic [31:0] A_IEN   = BASE + 32'h0C;
    localparam logic [31:0] A_TCMP  = BASE + 32'h10;
    localparam logic [31:0] A_TCNT  = BASE + 32'h14;
    localparam logic [31:0] A_TSTAT = BASE + 32'h18;
    localparam logic [31:0] A_RSVD  = BASE + 32'h1C;

    logic          clk;
    logic          reset;
    logic          MemWrite;
    logic          MemRead;
    logic [31:0]   Address;
    logic [31:0]   WriteData;
    logic [31:0]   ReadData;
    logic          Hit;
    logic [IW-1:0] PortIn;
    logic [31:0]   PortOut;
    logic          Irq;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural register contents plus the last three PortIn samples.
    logic [31:0]   m_out, m_en, m_cmp, m_cnt;
    logic [IW-1:0] m_edge;
    logic          m_match, m_run;
    logic [IW-1:0] seen [3];

    io_bus_responder #(.BASE_ADDR(BASE), .IN_WIDTH(IW)) dut (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData), .Hit(Hit),
        .PortIn(PortIn), .PortOut(PortOut), .Irq(Irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] en_mask();
`ifdef IO_TIMER_EN
        return 32'h8000_00FF;
`else
        return 32'h0000_00FF;
`endif
    endfunction

    function automatic logic exp_hit(input logic [31:0] a);
        return a[31:5] == BASE[31:5];
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (!exp_hit(a)) return 32'd0;
        case (a[4:2])
            3'd0: return m_out;
            3'd1: return {24'd0, seen[1]};
            3'd2: return {24'd0, m_edge};
            3'd3: return m_en;
`ifdef IO_TIMER_EN
            3'd4: return m_cmp;
            3'd5: return m_cnt;
            3'd6: return {30'd0, m_run, m_match};
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic exp_irq();
        return (|(m_edge & m_en[IW-1:0])) | (m_match & m_en[31]);
    endfunction

    task automatic model_reset();
        m_out = '0; m_en = '0; m_cmp = '1; m_cnt = '0;
        m_edge = '0; m_match = 1'b0; m_run = 1'b0;
        for (int i = 0; i < 3; i++) seen[i] = '0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One rising edge: model next state from the inputs presented before the edge.
    task automatic tick();
        logic          wr;
        logic [2:0]    ix;
        logic [IW-1:0] pin, clr;
        logic [31:0]   n_out, n_en, n_cmp, n_cnt;
        logic [IW-1:0] n_edge;
        logic          n_match, n_run;
        wr  = MemWrite && exp_hit(Address);
        ix  = Address[4:2];
        pin = PortIn;
        n_out  = (wr && ix == 3'd0) ? WriteData : m_out;
        clr    = (wr && ix == 3'd2) ? WriteData[IW-1:0] : '0;
        n_edge = (m_edge & ~clr) | (seen[1] & ~seen[2]);
        n_en   = (wr && ix == 3'd3) ? (WriteData & en_mask()) : m_en;
        n_cmp = m_cmp; n_cnt = m_cnt; n_match = m_match; n_run = m_run;
`ifdef IO_TIMER_EN
        if (wr && ix == 3'd4) n_cmp = WriteData;
        if (wr && ix == 3'd5) n_cnt = WriteData;
        else if (m_run) n_cnt = (m_cnt == m_cmp) ? 32'd0 : m_cnt + 32'd1;
        n_match = (m_run && !(wr && ix == 3'd5) && m_cnt == m_cmp)
                  || (m_match && !(wr && ix == 3'd6 && WriteData[0]));
        if (wr && ix == 3'd6) n_run = WriteData[1];
`endif
        @(posedge clk);
        m_out = n_out; m_en = n_en; m_cmp = n_cmp; m_cnt = n_cnt;
        m_edge = n_edge; m_match = n_match; m_run = n_run;
        seen[2] = seen[1]; seen[1] = seen[0]; seen[0] = pin;
        @(negedge clk);
    endtask

    task automatic drive(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        MemWrite = w; MemRead = r; Address = a; WriteData = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        drive(1'b1, 1'b0, a, d);
        tick();
        idle();
    endtask

    task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] expv);
        drive(1'b0, 1'b1, a, 32'd0);
        #1;
        check(tag, ReadData, expv);
        idle();
    endtask

    initial begin
        logic [31:0] a, d;
        reset = 1'b0;
        PortIn = '0;
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_portout_held", PortOut, 32'd0);
        reset = 1'b1;
        #1;
        check("rst_portout", PortOut, 32'd0);
        check("rst_irq", 32'(Irq), 32'd0);
        bus_rd("rst_out", A_OUT, 32'd0);
`ifdef IO_TIMER_EN
        bus_rd("rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
`else
        bus_rd("rst_tcmp_absent", A_TCMP, 32'd0);
`endif
        drive(1'b0, 1'b0, 32'h1001_0000, 32'd0);
        #1;
        check("hit_base", 32'(Hit), 32'd1);
        @(negedge clk);

        // OUT store, miss store, read-during-write
        bus_wr(A_OUT, 32'hA5A5_00FF);
        check("out_store", PortOut, 32'hA5A5_00FF);
        drive(1'b1, 1'b1, 32'h1002_0000, 32'h0000_1234);
        #1;
        check("miss_hit", 32'(Hit), 32'd0);
        check("miss_rdata", ReadData, 32'd0);
        tick();
        idle();
        check("miss_out", PortOut, 32'hA5A5_00FF);
        drive(1'b1, 1'b1, A_OUT, 32'h0000_BEEF);
        #1;
        check("rdw_old", ReadData, 32'hA5A5_00FF);
        tick();
        idle();
        check("rdw_new", PortOut, 32'h0000_BEEF);
        bus_wr(A_RSVD, 32'hFFFF_FFFF);
        bus_rd("rsvd", A_RSVD, 32'd0);

        // input sync and edge detect
        PortIn = 8'h81;
        tick();
        bus_rd("in_edge1", A_IN, 32'd0);
        tick();
        bus_rd("in_edge2", A_IN, 32'h81);
        bus_rd("edge_edge2", A_EDGE, 32'd0);
        tick();
        bus_rd("edge_edge3", A_EDGE, 32'h81);
        check("irq_no_en", 32'(Irq), 32'd0);
        bus_wr(A_IEN, 32'h0000_0001);
        check("irq_en", 32'(Irq), 32'd1);
        bus_wr(A_EDGE, 32'h0000_0001);
        bus_rd("edge_w1c", A_EDGE, 32'h80);
        check("irq_cleared", 32'(Irq), 32'd0);
        PortIn = 8'h83;
        tick();
        tick();
        bus_wr(A_EDGE, 32'h0000_0002);
        bus_rd("edge_set_wins", A_EDGE, 32'h82);

`ifdef IO_TIMER_EN
        bus_wr(A_TCMP, 32'd3);
        bus_wr(A_IEN, 32'h8000_0000);
        bus_wr(A_TSTAT, 32'd2);
        bus_rd("tcnt_0", A_TCNT, 32'd0);
        tick(); bus_rd("tcnt_1", A_TCNT, 32'd1); check("irq_t1", 32'(Irq), 32'd0);
        tick(); bus_rd("tcnt_2", A_TCNT, 32'd2);
        tick(); bus_rd("tcnt_3", A_TCNT, 32'd3); check("irq_t3", 32'(Irq), 32'd0);
        tick(); bus_rd("tcnt_wrap", A_TCNT, 32'd0);
        check("irq_match", 32'(Irq), 32'd1);
        bus_rd("tstat_match", A_TSTAT, 32'd3);
        tick(); tick(); tick();
        bus_rd("tcnt_3b", A_TCNT, 32'd3);
        bus_wr(A_TSTAT, 32'd3);
        bus_rd("match_set_wins", A_TSTAT, 32'd3);
        bus_rd("tcnt_wrap2", A_TCNT, 32'd0);
        bus_wr(A_TSTAT, 32'd3);
        bus_rd("match_w1c", A_TSTAT, 32'd2);
        check("irq_match_clr", 32'(Irq), 32'd0);
        tick(); tick();
        bus_rd("tcnt_3c", A_TCNT, 32'd3);
        bus_wr(A_TCNT, 32'h10);
        bus_rd("tcnt_load_wins", A_TCNT, 32'h10);
        bus_rd("tcnt_load_nomatch", A_TSTAT, 32'd2);
        tick();
        bus_rd("tcnt_after_load", A_TCNT, 32'h11);
`else
        bus_wr(A_TCMP, 32'd5);
        bus_rd("tcmp_absent", A_TCMP, 32'd0);
        bus_wr(A_TSTAT, 32'd3);
        bus_rd("tstat_absent", A_TSTAT, 32'd0);
        bus_wr(A_IEN, 32'h8000_0000);
        bus_rd("ien31_absent", A_IEN, 32'd0);
        check("irq_no_timer", 32'(Irq), 32'd0);
`endif

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 7) == 0) ? (32'h1002_0000 | ($urandom & 32'h1F))
                                            : (BASE | ($urandom & 32'h1F));
            d = $urandom;
            if (a[4:2] == 3'd4 || a[4:2] == 3'd5) d = 32'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) PortIn = IW'($urandom);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d);
            #1;
            check("rnd_hit", 32'(Hit), 32'(exp_hit(a)));
            check("rnd_rdata", ReadData, MemRead ? exp_read(a) : 32'd0);
            check("rnd_portout", PortOut, m_out);
            check("rnd_irq", 32'(Irq), 32'(exp_irq()));
            tick();
        end
        idle();

        // asynchronous reset mid-operation, input held high through reset
        bus_wr(A_OUT, 32'h0000_1234);
        bus_wr(A_TSTAT, 32'd2);
        PortIn = 8'hFF;
        tick(); tick(); tick();
        check("pre_rst_out", PortOut, 32'h0000_1234);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("arst_portout", PortOut, 32'd0);
        check("arst_irq", 32'(Irq), 32'd0);
        bus_rd("arst_tcnt", A_TCNT, 32'd0);
        bus_rd("arst_edge", A_EDGE, 32'd0);
        bus_rd("arst_in", A_IN, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        bus_rd("held_edge1", A_EDGE, 32'd0);
        tick();
        bus_rd("held_in2", A_IN, 32'hFF);
        bus_rd("held_edge2", A_EDGE, 32'd0);
        tick();
        bus_rd("held_edge3", A_EDGE, 32'hFF);
        bus_rd("held_tcnt", A_TCNT, 32'd0);
        bus_wr(A_EDGE, 32'hFF);
        tick(); tick();
        bus_rd("held_single", A_EDGE, 32'd0);
        bus_rd("held_model", A_EDGE, exp_read(A_EDGE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_bus_responder.md
Name: io_bus_responder

Overview:
- Memory-mapped I/O responder on the processor data bus: the slave end of the load/store interface.
- Owns the PortOut register, synchronizes and edge-detects PortIn, and provides a compare timer and a level interrupt.
- Instantiated next to the data memory in MIPS_Processor. Hit steers the writeback mux between data memory and this block.
- Reads are combinational from registered state (single-cycle core, no stall). Writes commit on the rising clock edge.

Parameters:
BASE_ADDR, 32'h1001_0000, base of the 32-byte register window; bits [4:0] must be zero
IN_WIDTH, 8, width of PortIn (1..32)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately, independent of clk)
MemWrite  input  1  store strobe for the current cycle
MemRead  input  1  load strobe for the current cycle
Address  input  32  byte address from the ALU result
WriteData  input  32  store data (ReadData2)
ReadData  output  32  load data; 0 when not selected
Hit  output  1  Address[31:5]==BASE_ADDR[31:5]
PortIn  input  IN_WIDTH  asynchronous external inputs
PortOut  output  32  OUT register value
Irq  output  1  level interrupt request

Behaviour:
- Decode: selected when Hit=1. Word index is Address[4:2]; Address[1:0] is ignored. Accesses with Hit=0 have no effect.
- Register map (offsets):
  - 0x00 OUT: RW.
  - 0x04 IN: RO, zero-extended synchronized PortIn.
  - 0x08 EDGE: [IN_WIDTH-1:0] sticky rising-edge flags, write-1-to-clear.
  - 0x0C IEN: [IN_WIDTH-1:0] edge enables, [31] timer enable; other bits read 0.
  - 0x10 TCMP: RW.
  - 0x14 TCNT: RW; a write loads the counter.
  - 0x18 TSTAT: bit0 match flag (W1C), bit1 RUN (RW).
  - 0x1C: reads 0, writes ignored.
- ReadData = selected register when MemRead & Hit, else 0.
- Simultaneous MemRead and MemWrite to the same register: ReadData shows the pre-write value.
- Input path:
  - Two-flop synchronizer s1→s2, plus delay flop s3.
  - IN reflects s2: a PortIn change is readable after the 2nd rising edge.
  - rise = s2 & ~s3. The EDGE bit sets on the 3rd edge.
- EDGE set/clear collision: a hardware set and a W1C clear of the same bit in the same cycle leaves the bit at 1 (set wins).
- Timer, when RUN=1:
  - If TCNT==TCMP: next edge TCNT←0 and match flag←1.
  - Otherwise TCNT←TCNT+1, wrapping 0xFFFF_FFFF→0.
  - A software write to TCNT takes priority over increment and compare-reload in that cycle.
  - Match set beats a W1C clear in the same cycle.
  - RUN=0 freezes TCNT.
- Irq = |(EDGE & IEN[IN_WIDTH-1:0]) | (match & IEN[31]). Combinational from registers, so no extra latency.
- Reset values: OUT, EDGE, IEN, TCNT, TSTAT = 0; TCMP = 32'hFFFF_FFFF; s1/s2/s3 = 0. Outputs PortOut=0, Irq=0, ReadData=0.
- Reset asserted mid-operation: all state clears asynchronously. The first edge after release resumes normally.
- An input held high through reset produces a single EDGE flag after release.

Optional Feature:
- Macro IO_TIMER_EN.
- Defined: TCMP/TCNT/TSTAT and IEN[31] are implemented as described.
- Undefined:
  - No timer logic.
  - Offsets 0x10/0x14/0x18 read 0 and ignore writes.
  - IEN[31] reads 0.
  - Irq is driven by the edge term only.

Test Plan:
- Reset, then load 0x1001_0000 → ReadData=0, PortOut=0, Irq=0; load 0x1001_0010 → 0xFFFF_FFFF (IO_TIMER_EN).
- Store 0xA5A5_00FF to 0x1001_0000 → PortOut=0xA5A5_00FF next edge. Store to 0x1002_0000 → Hit=0, PortOut unchanged.
- PortIn 0x00→0x81 → IN=0x81 after 2 edges; EDGE=0x81 after 3 edges. IEN=0x01 → Irq=1. Store 0x01 to EDGE → EDGE=0x80, Irq=0.
- TCMP=3, RUN=1, IEN[31]=1 → TCNT 0,1,2,3,0; match and Irq rise with the wrap. W1C clear in the same cycle as the next match → flag stays 1.
- Store to TCNT colliding with a compare match → TCNT=written value, flag not set.
- Assert reset asynchronously mid-count with OUT=0x1234 → PortOut=0, TCNT=0, EDGE=0 before the next clk edge.
